// File: rtl/a2g_lut_dump_pacer.sv
// Paced read-out of the a2g LUT onto a valid/ready stream, one word every period cycles.
// Optional overrun counter: define A2G_LUT_DUMP_OVERRUN_CNT_EN (otherwise overrun_cnt is tied to 0).
module a2g_lut_dump_pacer #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int PERIOD_W = 32
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [PERIOD_W-1:0] dump_data_period,
  input  logic                dump_start,
  output logic [ADDR_W-1:0]   lut_addr,
  output logic                lut_rd_en,
  input  logic [DATA_W-1:0]   lut_rd_data,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic                dump_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_start_q;
  logic [ADDR_W-1:0]   r_addr;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_timer;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;

  logic                w_start_evt;
  logic                w_slot_free;
  logic                w_hs;
  logic                w_timer_zero;
  logic                w_wait_go;
  logic                w_read;
  logic                w_addr_last;
  logic [PERIOD_W-1:0] w_period_eff;
  logic [PERIOD_W-1:0] w_timer_dec;

  assign w_start_evt  = dump_start & ~r_start_q & (r_state == S_IDLE);
  assign w_period_eff = (dump_data_period < PERIOD_W'(2)) ? PERIOD_W'(2) : dump_data_period;
  assign w_slot_free  = ~r_valid | dump_ready;
  assign w_hs         = r_valid & dump_ready;
  assign w_timer_zero = (r_timer == '0);
  assign w_timer_dec  = w_timer_zero ? '0 : r_timer - PERIOD_W'(1);
  assign w_wait_go    = (r_state == S_WAIT) & w_timer_zero & w_slot_free;
  assign w_read       = (r_state == S_READ) | w_wait_go;
  assign w_addr_last  = &r_addr;

  // NOTE: read strobe and done are decoded from registered state plus dump_ready, so a
  // stalled read issues in the very cycle the pending beat is accepted and no slot is wasted.
  assign lut_rd_en  = w_read;
  assign lut_addr   = r_addr;
  assign done       = (r_state == S_DRAIN) & w_hs;
  assign dump_data  = r_data;
  assign dump_valid = r_valid;
  assign dump_last  = r_last;
  assign busy       = r_busy;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_addr    <= '0;
      r_period  <= '0;
      r_timer   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_start_q <= dump_start;

      // Each read reloads the spacing timer; it then runs down to 0 and holds there.
      if (w_read) begin
        r_timer <= r_period - PERIOD_W'(1);
      end else if (r_state == S_CAPTURE || r_state == S_WAIT) begin
        r_timer <= w_timer_dec;
      end

      // A read is only issued when the slot is free, so CAPTURE never overwrites a live beat.
      if (r_state == S_CAPTURE) begin
        r_data  <= lut_rd_data;
        r_valid <= 1'b1;
        r_last  <= w_addr_last;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_evt) begin
            r_period <= w_period_eff;
            r_addr   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_addr_last) begin
            r_state <= S_DRAIN;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_wait_go) begin
            r_state <= S_CAPTURE;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef A2G_LUT_DUMP_OVERRUN_CNT_EN
  logic [15:0] r_overrun;

  // Counts cycles where pacing is due but the downstream still holds the previous beat.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_overrun <= '0;
    end else if (w_start_evt) begin
      r_overrun <= '0;
    end else if ((r_state == S_WAIT) && w_timer_zero && r_valid && !dump_ready &&
                 (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_a2g_lut_dump_pacer.sv
// Scoreboard bench for a2g_lut_dump_pacer (ADDR_W=3): expected beats are queued at each start,
// a negedge monitor checks the stream, read pacing, busy/done and the overrun count.
module tb_a2g_lut_dump_pacer;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 32;
  localparam int PERIOD_W = 32;
  localparam int N        = 1 << ADDR_W;
`ifdef A2G_LUT_DUMP_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic                user_clk = 1'b0;
  logic                user_rst = 1'b0;
  logic [PERIOD_W-1:0] dump_data_period = '0;
  logic                dump_start = 1'b0;
  logic [ADDR_W-1:0]   lut_addr;
  logic                lut_rd_en;
  logic [DATA_W-1:0]   lut_rd_data = '0;
  logic [DATA_W-1:0]   dump_data;
  logic                dump_valid;
  logic                dump_ready = 1'b1;
  logic                dump_last;
  logic                busy;
  logic                done;
  logic [15:0]         overrun_cnt;

  a2g_lut_dump_pacer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .dump_data_period(dump_data_period),
    .dump_start      (dump_start),
    .lut_addr        (lut_addr),
    .lut_rd_en       (lut_rd_en),
    .lut_rd_data     (lut_rd_data),
    .dump_data       (dump_data),
    .dump_valid      (dump_valid),
    .dump_ready      (dump_ready),
    .dump_last       (dump_last),
    .busy            (busy),
    .done            (done),
    .overrun_cnt     (overrun_cnt)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] lut [N];
  int                total = 0;
  int                bad = 0;

  // Model state shared between stimulus and monitor.
  bit                mon_en = 1'b0;
  bit                dump_active = 1'b0;
  int                start_cyc = 0;
  int                cur_p = 2;
  int                rd_cnt = 0;
  int                last_rd = 0;
  int                exp_ovr = 0;
  int                done_cyc = 0;
  bit                prev_valid = 1'b0;
  bit                prev_ready = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  bit                prev_last = 1'b0;
  bit                mon_hs;
  bit                mon_done_exp;
  beat_t             mon_beat;

  int                ready_mode = 0;
  int                lo_c = 0;
  int                hi_c = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // LUT memory: data for a read strobed in cycle r is presented throughout cycle r+1.
  initial begin
    logic              rd_pend;
    logic [ADDR_W-1:0] addr_pend;
    forever begin
      @(negedge user_clk);
      rd_pend   = lut_rd_en;
      addr_pend = lut_addr;
      @(posedge user_clk);
      #1;
      if (rd_pend) lut_rd_data = lut[addr_pend];
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = low inside [lo_c, hi_c].
  initial begin
    forever begin
      @(posedge user_clk);
      #1;
      case (ready_mode)
        1:       dump_ready = ($urandom_range(3) != 0);
        2:       dump_ready = !(cyc >= lo_c && cyc <= hi_c);
        default: dump_ready = 1'b1;
      endcase
    end
  end

  // Monitor: reads must come exactly P apart unless the stream is still holding a beat.
  always @(negedge user_clk) begin
    if (mon_en && !user_rst) begin
      mon_hs       = dump_valid && dump_ready;
      mon_done_exp = 1'b0;
      check("busy", busy, dump_active && (cyc > start_cyc));
      if (prev_valid && !prev_ready) begin
        check("hold_valid", dump_valid, 1);
        check("hold_data", dump_data, prev_data);
        check("hold_last", dump_last, prev_last);
      end
      if (lut_rd_en) begin
        check("rd_allowed", dump_active && rd_cnt < N, 1);
        check("rd_slot_free", !dump_valid || dump_ready, 1);
        check("rd_addr", lut_addr, rd_cnt);
        if (rd_cnt == 0) check("first_rd_cycle", cyc - start_cyc, 1);
        else check("rd_spacing_min", (cyc - last_rd) >= cur_p, 1);
        rd_cnt++;
        last_rd = cyc;
      end else if (dump_active && rd_cnt > 0 && rd_cnt < N && cyc >= last_rd + cur_p) begin
        check("rd_late", dump_valid && !dump_ready, 1);
        exp_ovr++;
      end
      if (mon_hs) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_beat = exp_q.pop_front();
          check("beat_data", dump_data, mon_beat.data);
          check("beat_last", dump_last, mon_beat.last);
          mon_done_exp = mon_beat.last;
        end
      end
      check("done", done, mon_done_exp);
      if (mon_done_exp) begin
        done_cyc = cyc;
        check("overrun_cnt", overrun_cnt, OVR_EN ? exp_ovr : 0);
        dump_active = 1'b0;
      end
      prev_valid = dump_valid;
      prev_ready = dump_ready;
      prev_data  = dump_data;
      prev_last  = dump_last;
    end
  end

  task automatic start_dump(input int unsigned p);
    @(posedge user_clk);
    #1;
    dump_start = 1'b0;
    @(posedge user_clk);
    #1;
    dump_data_period = p;
    dump_start       = 1'b1;
    start_cyc        = cyc;
    cur_p            = (p < 2) ? 2 : int'(p);
    rd_cnt           = 0;
    exp_ovr          = 0;
    dump_active      = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back('{data: lut[i], last: (i == N - 1)});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dump_active && n < budget) begin
      @(posedge user_clk);
      n++;
    end
    check("done_timeout", dump_active, 0);
    dump_active = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, dump_valid, 0);
    check({tag, "_data"}, dump_data, 0);
    check({tag, "_last"}, dump_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, lut_rd_en, 0);
    check({tag, "_addr"}, lut_addr, 0);
    check({tag, "_ovr"}, overrun_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) lut[i] = 32'hA500_0000 + i;
    #2 user_rst = 1'b1;
    repeat (3) @(posedge user_clk);
    #1;
    check_quiet("reset");
    user_rst = 1'b0;
    mon_en   = 1'b1;

    // Baseline pacing: reads at +1,+5,...,+29, done on +31.
    start_dump(4);
    wait_done(500);
    check("t1_done_cycle", done_cyc - start_cyc, 31);

    // Periods below 2 clamp to 2.
    start_dump(0);
    wait_done(500);
    start_dump(1);
    wait_done(500);

    // Backpressure on beat 2: ready low for 10 cycles.
    start_dump(3);
    lo_c       = start_cyc + 5;
    hi_c       = start_cyc + 14;
    ready_mode = 2;
    wait_done(500);
    check("t3_overrun", overrun_cnt, OVR_EN ? 8 : 0);
    ready_mode = 0;

    // Mid-dump start re-pulse and period change are ignored.
    start_dump(4);
    repeat (10) @(posedge user_clk);
    #1;
    dump_start = 1'b0;
    @(posedge user_clk);
    #1;
    dump_start       = 1'b1;
    dump_data_period = 100;
    wait_done(500);

    // Reset after the third beat, then a full dump from address 0.
    start_dump(4);
    begin
      int n = 0;
      while (exp_q.size() > N - 3 && n < 200) begin
        @(posedge user_clk);
        n++;
      end
    end
    @(posedge user_clk);
    #3;
    user_rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    dump_start  = 1'b0;
    dump_active = 1'b0;
    prev_valid  = 1'b0;
    exp_q.delete();
    @(posedge user_clk);
    #1;
    user_rst = 1'b0;
    start_dump(4);
    wait_done(500);

    // Start left high after done must not re-trigger.
    repeat (30) @(posedge user_clk);
    #1;
    check("held_no_dump_busy", busy, 0);
    check("held_no_dump_valid", dump_valid, 0);
    start_dump(5);
    wait_done(500);

    // Random contents, periods and backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) lut[i] = $urandom;
      ready_mode = 1;
      start_dump($urandom_range(6));
      wait_done(3000);
      ready_mode = 0;
    end

    repeat (5) @(posedge user_clk);
    #1;
    check("final_idle_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
